// File: rtl/watch_tick_ctrl.sv
// Upstream stage of the watch counter chain. It debounces the run and clear
// buttons, runs the STOP/RUN state machine, and divides clk into single-cycle
// tick pulses. It also emits a one-cycle clear request.
module watch_tick_ctrl #(
  parameter int unsigned DIV        = 40000000,
  parameter int unsigned FAST_DIV   = 400000,
  parameter int unsigned CNT_W      = 26,
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned DEB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run,
  input  logic btn_clr,
  input  logic fast,
  output logic tick,
  output logic running,
  output logic clr_pulse
);

  // Button lanes: index 0 = run, index 1 = clear
  localparam int unsigned NB = 2;
  localparam int unsigned BTN_RUN = 0;
  localparam int unsigned BTN_CLR = 1;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] FAST_M1  = CNT_W'(FAST_DIV - 1);

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync1;
  logic [NB-1:0]    sync2;
  logic [NB-1:0]    deb;
  logic [NB-1:0]    deb_d;
  logic [DEB_W-1:0] deb_cnt [NB];
  logic [NB-1:0]    press;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] presc;
  logic [CNT_W-1:0] presc_nx;
  logic [CNT_W-1:0] limit_m1;
  logic             wrap;
  logic             tick_nx;
  logic             clr_nx;
  logic             run_press;
  logic             clr_press;

  assign raw = {btn_clr, btn_run};

  // Two-flop synchroniser for the asynchronous button inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: a level change must be seen on DEB_CYCLES consecutive cycles, and any bounce restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < NB; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      deb_d <= deb;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= ~deb[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Single-cycle press on the debounced rising edge; release is ignored
  always_comb begin
    press     = deb & ~deb_d;
    run_press = press[BTN_RUN];
    clr_press = press[BTN_CLR];
    limit_m1  = fast ? FAST_M1 : DIV_M1;
  end

  // State register plus registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= STOP;
      presc     <= '0;
      tick      <= 1'b0;
      running   <= 1'b0;
      clr_pulse <= 1'b0;
    end else begin
      state     <= state_nx;
      presc     <= presc_nx;
      tick      <= tick_nx;
      running   <= (state_nx == RUN);
      clr_pulse <= clr_nx;
    end
  end

  // Next state, prescaler and outputs; clear wins over run, and a tick is dropped when the next state is STOP
  always_comb begin
    state_nx = state;
    presc_nx = presc;
    wrap     = 1'b0;
    tick_nx  = 1'b0;
    clr_nx   = 1'b0;

    if (clr_press) begin
      state_nx = STOP;
      clr_nx   = 1'b1;
    end else if (run_press) begin
      state_nx = (state == RUN) ? STOP : RUN;
    end

    // >= lets a count already past the fast limit wrap at once when fast goes high
    if (state == RUN) begin
      if (presc >= limit_m1) begin
        presc_nx = '0;
        wrap     = 1'b1;
      end else begin
        presc_nx = presc + CNT_W'(1);
      end
    end

    if (clr_press) begin
      presc_nx = '0;
    end

    tick_nx = wrap && (state_nx == RUN);
  end

endmodule

// File: tb/tb_watch_tick_ctrl.sv
// Bench for watch_tick_ctrl: directed timeline with literal expectations plus
// randomized buttons/fast, checked every cycle against a behavioural model.
module tb_watch_tick_ctrl;

  localparam int unsigned DIV        = 10;
  localparam int unsigned FAST_DIV   = 3;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned DEB_CYCLES = 4;
  localparam int unsigned DEB_W      = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_run = 1'b0;
  logic btn_clr = 1'b0;
  logic fast = 1'b0;
  logic tick;
  logic running;
  logic clr_pulse;

  int checks = 0;
  int passed = 0;
  int tk;

  watch_tick_ctrl #(
    .DIV(DIV), .FAST_DIV(FAST_DIV), .CNT_W(CNT_W),
    .DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)
  ) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_clr(btn_clr), .fast(fast),
    .tick(tick), .running(running), .clr_pulse(clr_pulse)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp_v);
    checks++;
    if (act == exp_v) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
  endfunction

  // Behavioural model. A button's debounced level flips once the last
  // DEB_CYCLES synchronised samples (raw value two edges old) all disagree
  // with it. A press acts one edge after the debounced level rises.
  bit          pipe   [2][2];
  bit          win    [2][DEB_CYCLES];
  bit          mdeb   [2];
  bit          rise   [2];
  bit          raw_now[2];
  bit          seen, all_diff, rp, cp, wrap;
  bit          m_run;
  int unsigned m_presc;
  int unsigned lim;
  bit          e_tick, e_run, e_clr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        pipe[b][0] = 1'b0; pipe[b][1] = 1'b0;
        for (int i = 0; i < DEB_CYCLES; i++) win[b][i] = 1'b0;
        mdeb[b] = 1'b0; rise[b] = 1'b0;
      end
      m_run = 1'b0; m_presc = 0;
      e_tick = 1'b0; e_run = 1'b0; e_clr = 1'b0;
    end else begin
      rp = rise[0];
      cp = rise[1];
      raw_now[0] = btn_run;
      raw_now[1] = btn_clr;
      for (int b = 0; b < 2; b++) begin
        seen = pipe[b][1];
        pipe[b][1] = pipe[b][0];
        pipe[b][0] = raw_now[b];
        for (int i = DEB_CYCLES - 1; i > 0; i--) win[b][i] = win[b][i-1];
        win[b][0] = seen;
        all_diff = 1'b1;
        for (int i = 0; i < DEB_CYCLES; i++) if (win[b][i] == mdeb[b]) all_diff = 1'b0;
        rise[b] = 1'b0;
        if (all_diff) begin
          mdeb[b] = ~mdeb[b];
          rise[b] = mdeb[b];
        end
      end
      lim = fast ? FAST_DIV : DIV;
      wrap = 1'b0;
      if (m_run) begin
        if (m_presc + 1 >= lim) begin m_presc = 0; wrap = 1'b1; end
        else m_presc = m_presc + 1;
      end
      if (cp) begin
        m_run = 1'b0; m_presc = 0; e_clr = 1'b1;
      end else begin
        e_clr = 1'b0;
        if (rp) m_run = !m_run;
      end
      e_tick = wrap && m_run;
      e_run  = m_run;
    end
  end

  // Every-cycle comparison of {tick,running,clr_pulse} against the model
  always @(negedge clk) begin
    check("model_outputs", int'({tick, running, clr_pulse}), int'({e_tick, e_run, e_clr}));
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({tick, running, clr_pulse}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean press: running at edge 7, ticks at 17, 27, ... 67
    btn_run = 1'b1;
    tk = 0;
    for (int k = 1; k <= 67; k++) begin
      @(negedge clk);
      if (k == 6) check("t1_run_pre", int'(running), 0);
      if (k == 7) check("t1_run_latency", int'(running), 1);
      if (k >= 8 && k <= 16) tk += int'(tick);
      if (k == 16) check("t1_no_early_tick", tk, 0);
      if (k == 17) begin check("t1_first_tick", int'(tick), 1); tk = 0; end
      if (k >= 18) tk += int'(tick);
      if (k == 67) check("t1_ticks_in_50", tk, 5);
      if (k == 10) btn_run = 1'b0;
    end

    // Bounce 1,0,1,0 then stable: one press, RUN -> STOP 7 edges later
    btn_run = 1'b1; @(negedge clk);
    btn_run = 1'b0; @(negedge clk);
    btn_run = 1'b1; @(negedge clk);
    btn_run = 1'b0; @(negedge clk);
    check("t2_bounce_no_toggle", int'(running), 1);
    btn_run = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 6) check("t2_run_pre", int'(running), 1);
      if (k == 7) check("t2_stop_latency", int'(running), 0);
    end
    btn_run = 1'b0;
    repeat (12) @(negedge clk);

    // Clear press in STOP: one-cycle clr_pulse, prescaler back to 0
    btn_clr = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 6) check("clr_pre", int'(clr_pulse), 0);
      if (k == 7) check("clr_pulse_on", int'({clr_pulse, running, tick}), 4);
      if (k == 8) check("clr_pulse_single", int'(clr_pulse), 0);
      if (k == 5) btn_clr = 1'b0;
    end
    repeat (15) @(negedge clk);

    // Timeline: run at 7, pause at 23 (prescaler 6), resume at 46 -> tick at 50,
    // fast at prescaler 7 -> tick at 58 then every 3, slow again -> 74, 84,
    // run+clear together -> clear at 87, run again at 106 -> tick at 116
    btn_run = 1'b1;
    tk = 0;
    for (int k = 1; k <= 121; k++) begin
      @(negedge clk);
      case (k)
        6:   check("t3_run_pre", int'(running), 0);
        7:   check("t3_run", int'(running), 1);
        16:  check("t3_no_early_tick", tk, 0);
        17:  check("t3_first_tick", int'(tick), 1);
        22:  check("t3_pause_pre", int'(running), 1);
        23:  check("t3_paused", int'(running), 0);
        45:  check("t3_resume_pre", int'(running), 0);
        46:  check("t3_resumed", int'(running), 1);
        49:  check("t3_no_tick_gap", tk, 0);
        50:  check("t3_tick_4_after_resume", int'(tick), 1);
        57:  check("t4_pre_fast", int'(tick), 0);
        58:  check("t4_fast_wrap_tick", int'(tick), 1);
        61:  check("t4_fast_tick_61", int'(tick), 1);
        63:  check("t4_fast_gap", tk, 1);
        64:  check("t4_fast_tick_64", int'(tick), 1);
        73:  check("t4_slow_gap", tk, 0);
        74:  check("t4_slow_tick", int'(tick), 1);
        84:  check("t4_slow_tick2", int'(tick), 1);
        86:  check("t5_pre", int'({clr_pulse, running}), 1);
        87:  check("t5_clear_wins", int'({clr_pulse, running, tick}), 4);
        88:  check("t5_clr_single", int'(clr_pulse), 0);
        105: check("t5_rerun_pre", int'(running), 0);
        106: check("t5_rerun", int'(running), 1);
        115: check("t5_presc_zero_gap", tk, 0);
        116: check("t5_tick_after_clear", int'(tick), 1);
        default: ;
      endcase
      if ((k >= 8 && k <= 16) || (k >= 18 && k <= 49) || (k >= 59 && k <= 63) ||
          (k >= 65 && k <= 73) || (k >= 107 && k <= 115)) tk += int'(tick);
      if (k == 16 || k == 49 || k == 63 || k == 73 || k == 115 || k == 58 || k == 64 || k == 106)
        tk = (k == 16 || k == 49 || k == 63 || k == 73 || k == 115) ? tk : 0;
      if (k == 17 || k == 58 || k == 64 || k == 106) tk = 0;
      case (k)
        5:   btn_run = 1'b0;
        16:  btn_run = 1'b1;
        21:  btn_run = 1'b0;
        39:  btn_run = 1'b1;
        44:  btn_run = 1'b0;
        57:  fast = 1'b1;
        64:  fast = 1'b0;
        80:  begin btn_run = 1'b1; btn_clr = 1'b1; end
        85:  begin btn_run = 1'b0; btn_clr = 1'b0; end
        99:  btn_run = 1'b1;
        104: btn_run = 1'b0;
        default: ;
      endcase
    end

    // Asynchronous reset while running at prescaler 5
    #2 rst = 1'b1;
    #1 check("t6_async_reset", int'({tick, running, clr_pulse}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tk = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      tk += int'(tick) + int'(running) + int'(clr_pulse);
    end
    check("t6_quiet_after_reset", tk, 0);

    // Randomized buttons, fast and one short async reset
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) btn_run = ~btn_run;
      if ($urandom_range(0, 11) == 0) btn_clr = ~btn_clr;
      if ($urandom_range(0, 40) == 0) fast = ~fast;
      if (i == 1500) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
